// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : Memory-stage data-bus controller. Turns the load/store held  |
// |               in the M pipeline register into exactly one dbus transaction |
// |               (valid held until addr_ok, then wait for data_ok). It also   |
// |               returns the aligned, extended load result to the M->W        |
// |               register and raises the stall request to the hazard unit.    |
// | Ports       : clk, resetn (synchronous, active low)                        |
// |               op_i/we_i/addr_i/wdata_i/size_i/signed_i  - op in M          |
// |               flush_i, pipe_adv_i                       - pipeline control |
// |               dbus_* (valid/addr/size/strobe/wdata out,                    |
// |                       addr_ok/data_ok/rdata in)         - data bus         |
// |               rdata_o, stall_o, adel_o, ades_o          - results          |
// | Config      : `define MEM_ALIGN_CHECK_EN to block misaligned halfword/word |
// |               accesses and report them on adel_o/ades_o. Without it every  |
// |               op is issued as-is and adel_o/ades_o are tied to 0.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package mem_access_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // only 32 is supported (4 byte lanes)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  msize_t            size_i,
    input  logic              signed_i,
    input  logic              flush_i,
    input  logic              pipe_adv_i,
    output logic              dbus_valid_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output msize_t            dbus_size_o,
    output logic [3:0]        dbus_strobe_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_addr_ok,
    input  logic              dbus_data_ok,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              adel_o,
    output logic              ades_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no transaction outstanding
        S_ADDR = 2'd1,   // request valid, waiting for addr_ok
        S_DATA = 2'd2,   // address accepted, waiting for data_ok
        S_DONE = 2'd3    // result held until the M->W register captures it
    } state_t;

    state_t            r_state;
    logic              r_kill;
    logic [DATA_W-1:0] r_rdata;

    // Request payload captured at issue so that it stays stable until
    // addr_ok and so the load result can be extracted later in S_DATA.
    logic [ADDR_W-1:0] r_addr;
    msize_t            r_size;
    logic              r_we;
    logic              r_signed;
    logic [DATA_W-1:0] r_wdata;

    logic              w_misalign;
    logic              w_selIdle;
    logic              w_issue;
    logic              w_addrPhase;
    logic              w_complete;
    logic              w_killNow;
    logic              w_payloadOn;

    logic [ADDR_W-1:0] w_addr;
    msize_t            w_size;
    logic              w_we;
    logic              w_signed;
    logic [DATA_W-1:0] w_wdata;

    logic [3:0]        w_strobe;
    logic [DATA_W-1:0] w_wdataLanes;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((size_i == MSIZE2) && addr_i[0]) ||
                        ((size_i == MSIZE4) && (addr_i[1:0] != 2'b00));
    assign adel_o     = op_i & w_misalign & ~we_i;
    assign ades_o     = op_i & w_misalign &  we_i;
`else
    assign w_misalign = 1'b0;
    assign adel_o     = 1'b0;
    assign ades_o     = 1'b0;
`endif

    // In IDLE the request comes straight from the pipeline register (zero-wait
    // issue); in every other state it comes from the captured copy.
    assign w_selIdle = (r_state == S_IDLE);
    assign w_addr    = w_selIdle ? addr_i   : r_addr;
    assign w_size    = w_selIdle ? size_i   : r_size;
    assign w_we      = w_selIdle ? we_i     : r_we;
    assign w_signed  = w_selIdle ? signed_i : r_signed;
    assign w_wdata   = w_selIdle ? wdata_i  : r_wdata;

    assign w_issue     = w_selIdle & op_i & ~flush_i & ~w_misalign;
    assign w_addrPhase = w_issue | (r_state == S_ADDR);
    assign w_complete  = (w_addrPhase & dbus_addr_ok & dbus_data_ok) |
                         ((r_state == S_DATA) & dbus_data_ok);
    // A flush arriving on the completion cycle itself must also keep the
    // result out of S_DONE, hence the combinational term next to r_kill.
    assign w_killNow   = r_kill |
                         (flush_i & ((r_state == S_ADDR) | (r_state == S_DATA)));
    assign w_payloadOn = ~w_selIdle | op_i;

    // Store lane placement: data is replicated across the word so the slave
    // can pick it up on whichever lanes the strobe enables.
    always_comb begin
        w_strobe     = 4'b0000;
        w_wdataLanes = w_wdata;
        case (w_size)
            MSIZE1: begin
                w_strobe     = 4'b0001 << w_addr[1:0];
                w_wdataLanes = {4{w_wdata[7:0]}};
            end
            MSIZE2: begin
                w_strobe     = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdataLanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_strobe     = 4'b1111;
            end
        endcase
        if (!w_we) begin
            w_strobe = 4'b0000;
        end
    end

    // Load extraction; a halfword is always taken from the lane chosen by
    // addr[1], so addr[0] is ignored for halfwords when no check is built in.
    always_comb begin
        w_byte = dbus_rdata[{w_addr[1:0], 3'b000} +: 8];
        w_half = w_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (w_size)
            MSIZE1:  w_load = {{(DATA_W-8){w_signed & w_byte[7]}}, w_byte};
            MSIZE2:  w_load = {{(DATA_W-16){w_signed & w_half[15]}}, w_half};
            default: w_load = dbus_rdata;
        endcase
    end

    assign dbus_valid_o  = w_addrPhase;
    assign dbus_addr_o   = w_payloadOn ? w_addr       : '0;
    assign dbus_size_o   = w_payloadOn ? w_size       : MSIZE1;
    assign dbus_strobe_o = w_payloadOn ? w_strobe     : 4'b0000;
    assign dbus_wdata_o  = w_payloadOn ? w_wdataLanes : '0;

    assign rdata_o = w_complete              ? w_load :
                     (w_selIdle & ~op_i)     ? '0     : r_rdata;

    // A flushed or blocked op in IDLE never stalls; an outstanding
    // transaction (killed or not) stalls until its data_ok.
    always_comb begin
        case (r_state)
            S_IDLE:  stall_o = w_issue & ~w_complete;
            S_ADDR:  stall_o = ~w_complete;
            S_DATA:  stall_o = ~w_complete;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_kill   <= 1'b0;
            r_rdata  <= '0;
            r_addr   <= '0;
            r_size   <= MSIZE1;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_addr   <= addr_i;
                        r_size   <= size_i;
                        r_we     <= we_i;
                        r_signed <= signed_i;
                        r_wdata  <= wdata_i;
                        r_state  <= dbus_addr_ok ? S_DATA : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (dbus_addr_ok) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (pipe_adv_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Completion overrides the per-state moves above.
            if (w_complete) begin
                r_rdata <= w_load;
                r_kill  <= 1'b0;
                r_state <= (~pipe_adv_i & ~w_killNow) ? S_DONE : S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire
